// File: rtl/loteria_multi.sv
`default_nettype none
// ============================================================================
// Module      : loteria_multi
// Description : Lottery bet checker. A game starts with novo_jogo, which
//               latches the drawn number. Bet digits then arrive one per
//               insere pulse and are compared position by position against
//               the draw. The longest run of consecutive matching digits
//               decides the prize, which is reported one cycle after the
//               last digit and counted in saturating win counters.
//
// Ports       : clock_i          rising-edge clock
//               reset_n_i        asynchronous active-low reset
//               sorteio_i        drawn number, digit 0 in the MS nibble
//               novo_jogo_i      start a game, latch sorteio_i
//               insere_i         numero_i is valid this cycle
//               numero_i         bet digit
//               fim_i            abort the current game
//               clear_stats_i    synchronous clear of the win counters
//               premio_o         00 none, 01 prize 1, 10 prize 2
//               premio_valid_o   one-cycle pulse when premio_o is updated
//               p1_o / p2_o      prize-1 / prize-2 win counters (saturating)
//               jogos_o          completed-game counter (optional)
//               busy_o           high while a game is in PLAY or SCORE
//
// Options     : LOTERIA_JOGOS_COUNT_EN - when defined, adds jogos_o, a
//               saturating count of games that reached scoring.
//
// Revision    : 1.0 - initial release
// ============================================================================

module loteria_multi #(
    parameter int DIGITS  = 5,
    parameter int DIGIT_W = 4,
    parameter int P1_RUN  = 4,
    parameter int P2_RUN  = 2,
    parameter int COUNT_W = 5
) (
    input  logic                        clock_i,
    input  logic                        reset_n_i,
    input  logic [DIGITS*DIGIT_W-1:0]   sorteio_i,
    input  logic                        novo_jogo_i,
    input  logic                        insere_i,
    input  logic [DIGIT_W-1:0]          numero_i,
    input  logic                        fim_i,
    input  logic                        clear_stats_i,
    output logic [1:0]                  premio_o,
    output logic                        premio_valid_o,
    output logic [COUNT_W-1:0]          p1_o,
    output logic [COUNT_W-1:0]          p2_o,
`ifdef LOTERIA_JOGOS_COUNT_EN
    output logic [COUNT_W-1:0]          jogos_o,
`endif
    output logic                        busy_o
);

    // Index, run and max must be able to hold the value DIGITS itself
    // (index after the last digit, run/max after an all-match bet).
    localparam int IDX_W = $clog2(DIGITS + 1);

    localparam logic [IDX_W-1:0]   LAST_IDX     = IDX_W'(DIGITS - 1);
    localparam logic [IDX_W-1:0]   P1_THR       = IDX_W'(P1_RUN);
    localparam logic [IDX_W-1:0]   P2_THR       = IDX_W'(P2_RUN);
    localparam logic [COUNT_W-1:0] COUNT_MAX    = {COUNT_W{1'b1}};
    localparam logic [1:0]         PREMIO_NONE  = 2'b00;
    localparam logic [1:0]         PREMIO_P1    = 2'b01;
    localparam logic [1:0]         PREMIO_P2    = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PLAY  = 2'd1,
        S_SCORE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                      state_q,   state_d;
    logic [DIGITS*DIGIT_W-1:0]   draw_q,    draw_d;
    logic [IDX_W-1:0]            idx_q,     idx_d;
    logic [IDX_W-1:0]            run_q,     run_d;
    logic [IDX_W-1:0]            max_q,     max_d;
    logic [1:0]                  premio_q,  premio_d;
    logic                        valid_q,   valid_d;
    logic                        busy_q,    busy_d;
    logic [COUNT_W-1:0]          p1_q,      p1_d;
    logic [COUNT_W-1:0]          p2_q,      p2_d;
`ifdef LOTERIA_JOGOS_COUNT_EN
    logic [COUNT_W-1:0]          jogos_q,   jogos_d;
`endif

    // ------------------------------------------------------------------
    // Split the latched draw into digits, digit 0 being the most
    // significant field.
    // ------------------------------------------------------------------
    logic [DIGIT_W-1:0] w_digit [DIGITS];

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
        assign w_digit[gi] = draw_q[(DIGITS-1-gi)*DIGIT_W +: DIGIT_W];
    end

    // Compare-based mux keeps the select width independent of DIGITS.
    logic [DIGIT_W-1:0] w_cur_digit;
    always_comb begin
        w_cur_digit = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                w_cur_digit = w_digit[i];
            end
        end
    end

    logic [IDX_W-1:0] w_run_inc;
    logic             w_match;
    logic [1:0]       w_score;
    logic             w_score_exit;

    assign w_run_inc = run_q + IDX_W'(1);
    assign w_match   = (numero_i == w_cur_digit);

    // Prize 1 wins over prize 2 since its threshold is the stricter one.
    assign w_score = (max_q >= P1_THR) ? PREMIO_P1 :
                     (max_q >= P2_THR) ? PREMIO_P2 : PREMIO_NONE;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        draw_d       = draw_q;
        idx_d        = idx_q;
        run_d        = run_q;
        max_d        = max_q;
        premio_d     = premio_q;
        valid_d      = 1'b0;
        busy_d       = busy_q;
        w_score_exit = 1'b0;

        if (novo_jogo_i) begin
            // A new game pre-empts everything, including a pending score.
            state_d  = S_PLAY;
            draw_d   = sorteio_i;
            idx_d    = '0;
            run_d    = '0;
            max_d    = '0;
            premio_d = PREMIO_NONE;
            busy_d   = 1'b1;
        end else begin
            case (state_q)
                S_PLAY: begin
                    if (fim_i) begin
                        // Abort wins over a simultaneous digit.
                        state_d  = S_IDLE;
                        premio_d = PREMIO_NONE;
                        busy_d   = 1'b0;
                    end else if (insere_i) begin
                        if (w_match) begin
                            run_d = w_run_inc;
                            if (w_run_inc > max_q) begin
                                max_d = w_run_inc;
                            end
                        end else begin
                            run_d = '0;
                        end
                        idx_d = idx_q + IDX_W'(1);
                        if (idx_q == LAST_IDX) begin
                            state_d = S_SCORE;
                        end
                    end
                end
                S_SCORE: begin
                    premio_d     = w_score;
                    valid_d      = 1'b1;
                    busy_d       = 1'b0;
                    state_d      = S_DONE;
                    w_score_exit = 1'b1;
                end
                default: begin
                    // IDLE and DONE hold premio and ignore insere/fim.
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Win counters: clear has priority over an increment in the same
    // cycle, and counters stick at all-ones.
    // ------------------------------------------------------------------
    always_comb begin
        p1_d = p1_q;
        p2_d = p2_q;
        if (clear_stats_i) begin
            p1_d = '0;
            p2_d = '0;
        end else if (w_score_exit) begin
            if (w_score == PREMIO_P1 && p1_q != COUNT_MAX) begin
                p1_d = p1_q + COUNT_W'(1);
            end
            if (w_score == PREMIO_P2 && p2_q != COUNT_MAX) begin
                p2_d = p2_q + COUNT_W'(1);
            end
        end
    end

`ifdef LOTERIA_JOGOS_COUNT_EN
    always_comb begin
        jogos_d = jogos_q;
        if (clear_stats_i) begin
            jogos_d = '0;
        end else if (w_score_exit && jogos_q != COUNT_MAX) begin
            jogos_d = jogos_q + COUNT_W'(1);
        end
    end
`endif

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q  <= S_IDLE;
            draw_q   <= '0;
            idx_q    <= '0;
            run_q    <= '0;
            max_q    <= '0;
            premio_q <= PREMIO_NONE;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            p1_q     <= '0;
            p2_q     <= '0;
`ifdef LOTERIA_JOGOS_COUNT_EN
            jogos_q  <= '0;
`endif
        end else begin
            state_q  <= state_d;
            draw_q   <= draw_d;
            idx_q    <= idx_d;
            run_q    <= run_d;
            max_q    <= max_d;
            premio_q <= premio_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            p1_q     <= p1_d;
            p2_q     <= p2_d;
`ifdef LOTERIA_JOGOS_COUNT_EN
            jogos_q  <= jogos_d;
`endif
        end
    end

    assign premio_o       = premio_q;
    assign premio_valid_o = valid_q;
    assign busy_o         = busy_q;
    assign p1_o           = p1_q;
    assign p2_o           = p2_q;
`ifdef LOTERIA_JOGOS_COUNT_EN
    assign jogos_o        = jogos_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_loteria_multi.sv
`default_nettype none
// ============================================================================
// Module      : tb_loteria_multi
// Description : Self-checking bench for loteria_multi. Expected results are
//               pushed to a scoreboard queue when the last bet digit is
//               driven and popped by a monitor when premio_valid pulses.
//               Counter width is reduced to 2 bits so saturation is
//               reached with a handful of games.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps

module tb_loteria_multi;

    localparam int DIGITS  = 5;
    localparam int DIGIT_W = 4;
    localparam int CW      = 2;
    localparam int CMAX    = (1 << CW) - 1;

    logic                      clk;
    logic                      rst_n;
    logic [DIGITS*DIGIT_W-1:0] sorteio;
    logic                      novo_jogo;
    logic                      insere;
    logic [DIGIT_W-1:0]        numero;
    logic                      fim;
    logic                      clear_stats;
    logic [1:0]                premio_o;
    logic                      premio_valid_o;
    logic [CW-1:0]             p1_o;
    logic [CW-1:0]             p2_o;
    logic                      busy_o;
`ifdef LOTERIA_JOGOS_COUNT_EN
    logic [CW-1:0]             jogos_o;
`endif

    loteria_multi #(
        .DIGITS  (DIGITS),
        .DIGIT_W (DIGIT_W),
        .P1_RUN  (4),
        .P2_RUN  (2),
        .COUNT_W (CW)
    ) u_dut (
        .clock_i        (clk),
        .reset_n_i      (rst_n),
        .sorteio_i      (sorteio),
        .novo_jogo_i    (novo_jogo),
        .insere_i       (insere),
        .numero_i       (numero),
        .fim_i          (fim),
        .clear_stats_i  (clear_stats),
        .premio_o       (premio_o),
        .premio_valid_o (premio_valid_o),
        .p1_o           (p1_o),
        .p2_o           (p2_o),
`ifdef LOTERIA_JOGOS_COUNT_EN
        .jogos_o        (jogos_o),
`endif
        .busy_o         (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [1:0] premio;
        int         p1;
        int         p2;
        int         stamp;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;

    // Reference model state
    logic [DIGITS*DIGIT_W-1:0] m_draw;
    int m_p1    = 0;
    int m_p2    = 0;
    int m_jogos = 0;

    // ------------------------------------------------------------------
    // Monitor: every premio_valid pulse must match the oldest expectation.
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        if (rst_n === 1'b1 && premio_valid_o === 1'b1) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: premio_valid=1 at cycle %0d, required 0", cyc);
            end else begin
                mon_e = sbq.pop_front();
                checks++;
                if (cyc !== mon_e.stamp) begin
                    errors++;
                    $display("FAIL pulse_latency: pulse at cycle %0d, required %0d", cyc, mon_e.stamp);
                end
                checks++;
                if (premio_o !== mon_e.premio) begin
                    errors++;
                    $display("FAIL premio: got %b, required %b", premio_o, mon_e.premio);
                end
                checks++;
                if (p1_o !== CW'(mon_e.p1)) begin
                    errors++;
                    $display("FAIL p1_at_pulse: got %0d, required %0d", p1_o, mon_e.p1);
                end
                checks++;
                if (p2_o !== CW'(mon_e.p2)) begin
                    errors++;
                    $display("FAIL p2_at_pulse: got %0d, required %0d", p2_o, mon_e.p2);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (entered and left at a falling edge)
    // ------------------------------------------------------------------
    task automatic start_game(input logic [DIGITS*DIGIT_W-1:0] draw);
        sorteio   = draw;
        m_draw    = draw;
        novo_jogo = 1'b1;
        @(negedge clk);
        novo_jogo = 1'b0;
    endtask

    task automatic insert_digits(input logic [DIGITS*DIGIT_W-1:0] bet, input int n);
        for (int i = 0; i < n; i++) begin
            numero = bet[(DIGITS-1-i)*DIGIT_W +: DIGIT_W];
            insere = 1'b1;
            @(negedge clk);
        end
        insere = 1'b0;
    endtask

    // mode 0: normal, 1: clear_stats during SCORE, 2: novo_jogo during SCORE
    task automatic play(input logic [DIGITS*DIGIT_W-1:0] bet, input int mode);
        int   run;
        int   mx;
        logic [1:0] prem;
        exp_t e;
        run = 0;
        mx  = 0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bet[(DIGITS-1-i)*DIGIT_W +: DIGIT_W] == m_draw[(DIGITS-1-i)*DIGIT_W +: DIGIT_W]) begin
                run++;
                if (run > mx) mx = run;
            end else begin
                run = 0;
            end
        end
        prem = (mx >= 4) ? 2'b01 : (mx >= 2) ? 2'b10 : 2'b00;

        for (int i = 0; i < DIGITS; i++) begin
            numero = bet[(DIGITS-1-i)*DIGIT_W +: DIGIT_W];
            insere = 1'b1;
            if (i == DIGITS - 1 && mode != 2) begin
                if (mode == 1) begin
                    m_p1    = 0;
                    m_p2    = 0;
                    m_jogos = 0;
                end else begin
                    if (prem == 2'b01 && m_p1 < CMAX) m_p1++;
                    if (prem == 2'b10 && m_p2 < CMAX) m_p2++;
                    if (m_jogos < CMAX) m_jogos++;
                end
                e.premio = prem;
                e.p1     = m_p1;
                e.p2     = m_p2;
                e.stamp  = cyc + 2;
                sbq.push_back(e);
            end
            @(negedge clk);
        end
        insere = 1'b0;
        // DUT is now in SCORE
        if (mode == 1) clear_stats = 1'b1;
        if (mode == 2) novo_jogo   = 1'b1;
        @(negedge clk);
        clear_stats = 1'b0;
        novo_jogo   = 1'b0;
        if (mode == 2) begin
            checks++;
            if (busy_o !== 1'b1 || premio_o !== 2'b00) begin
                errors++;
                $display("FAIL novo_over_score: busy=%b premio=%b, required busy=1 premio=00", busy_o, premio_o);
            end
            return;
        end
        for (int k = 0; k < 4 && sbq.size() != 0; k++) @(negedge clk);
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL result_timeout: %0d results outstanding, required 0", sbq.size());
            sbq.delete();
        end
        checks++;
        if (premio_o !== prem || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL premio_hold: premio=%b busy=%b, required premio=%b busy=0", premio_o, busy_o, prem);
        end
`ifdef LOTERIA_JOGOS_COUNT_EN
        checks++;
        if (jogos_o !== CW'(m_jogos)) begin
            errors++;
            $display("FAIL jogos: got %0d, required %0d", jogos_o, m_jogos);
        end
`endif
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({premio_o, premio_valid_o, busy_o, p1_o, p2_o} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: premio=%b valid=%b busy=%b p1=%0d p2=%0d, required all 0",
                     premio_o, premio_valid_o, busy_o, p1_o, p2_o);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({premio_o, premio_valid_o, busy_o, p1_o, p2_o} !== '0) begin
            errors++;
            $display("FAIL after_release: premio=%b valid=%b busy=%b p1=%0d p2=%0d, required all 0",
                     premio_o, premio_valid_o, busy_o, p1_o, p2_o);
        end
    endtask

    task automatic test_prize1();
        start_game(20'h53820);
        checks++;
        if (busy_o !== 1'b1) begin
            errors++;
            $display("FAIL busy_in_play: got %b, required 1", busy_o);
        end
        play(20'h53820, 0);
        checks++;
        if (p1_o !== 2'd1 || p2_o !== 2'd0) begin
            errors++;
            $display("FAIL prize1_counts: p1=%0d p2=%0d, required p1=1 p2=0", p1_o, p2_o);
        end
    endtask

    task automatic test_prize2();
        start_game(20'h53820);
        checks++;
        if (premio_o !== 2'b00) begin
            errors++;
            $display("FAIL novo_clears_premio: got %b, required 00", premio_o);
        end
        play(20'h53890, 0);
        checks++;
        if (p1_o !== 2'd1 || p2_o !== 2'd1) begin
            errors++;
            $display("FAIL prize2_counts: p1=%0d p2=%0d, required p1=1 p2=1", p1_o, p2_o);
        end
    endtask

    task automatic test_no_prize();
        start_game(20'h53820);
        play(20'h13121, 0);
        checks++;
        if (p1_o !== 2'd1 || p2_o !== 2'd1) begin
            errors++;
            $display("FAIL noprize_counts: p1=%0d p2=%0d, required p1=1 p2=1", p1_o, p2_o);
        end
    endtask

    task automatic test_abort();
        start_game(20'h53820);
        insert_digits(20'h53820, 2);
        fim = 1'b1;
        @(negedge clk);
        fim = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy_o !== 1'b0 || premio_o !== 2'b00 || p1_o !== CW'(m_p1) || p2_o !== CW'(m_p2)) begin
            errors++;
            $display("FAIL abort: busy=%b premio=%b p1=%0d p2=%0d, required busy=0 premio=00 p1=%0d p2=%0d",
                     busy_o, premio_o, p1_o, p2_o, m_p1, m_p2);
        end
    endtask

    task automatic test_ignored_inputs();
        // insere and fim in IDLE must not start or score anything
        fim = 1'b1;
        insert_digits(20'h53820, DIGITS);
        fim = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy_o !== 1'b0 || premio_o !== 2'b00) begin
            errors++;
            $display("FAIL idle_ignore: busy=%b premio=%b, required busy=0 premio=00", busy_o, premio_o);
        end
    endtask

    task automatic test_saturation();
        for (int g = 0; g < 4; g++) begin
            start_game(20'h53820);
            play(20'h53820, 0);
        end
        checks++;
        if (p1_o !== 2'd3) begin
            errors++;
            $display("FAIL p1_saturate: got %0d, required 3", p1_o);
        end
    endtask

    task automatic test_clear_with_score();
        start_game(20'h53820);
        play(20'h53820, 1);
        checks++;
        if (p1_o !== 2'd0 || p2_o !== 2'd0) begin
            errors++;
            $display("FAIL clear_priority: p1=%0d p2=%0d, required 0 0", p1_o, p2_o);
        end
    endtask

    task automatic test_back_to_back();
        start_game(20'h53820);
        play(20'h53820, 2);
        play(20'h53890, 0);
        start_game(20'h12345);
        play(20'h12305, 0);
        checks++;
        if (p1_o !== 2'd0 || p2_o !== 2'd2) begin
            errors++;
            $display("FAIL back_to_back: p1=%0d p2=%0d, required p1=0 p2=2", p1_o, p2_o);
        end
    endtask

    task automatic test_reset_midgame();
        start_game(20'h53820);
        insert_digits(20'h53820, 3);
        #2 rst_n = 1'b0;
        #1;
        m_p1    = 0;
        m_p2    = 0;
        m_jogos = 0;
        checks++;
        if ({premio_o, premio_valid_o, busy_o, p1_o, p2_o} !== '0) begin
            errors++;
            $display("FAIL async_reset: premio=%b valid=%b busy=%b p1=%0d p2=%0d, required all 0",
                     premio_o, premio_valid_o, busy_o, p1_o, p2_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (busy_o !== 1'b0 || premio_o !== 2'b00) begin
            errors++;
            $display("FAIL idle_after_reset: busy=%b premio=%b, required 0 00", busy_o, premio_o);
        end
        start_game(20'h53820);
        play(20'h53820, 0);
        checks++;
        if (p1_o !== 2'd1) begin
            errors++;
            $display("FAIL p1_after_reset: got %0d, required 1", p1_o);
        end
    endtask

`ifdef LOTERIA_JOGOS_COUNT_EN
    task automatic test_jogos();
        start_game(20'h53820);
        play(20'h13121, 0);
        start_game(20'h53820);
        insert_digits(20'h53820, 2);
        fim = 1'b1;
        @(negedge clk);
        fim = 1'b0;
        start_game(20'h53820);
        play(20'h53890, 0);
        checks++;
        if (jogos_o !== 2'd3) begin
            errors++;
            $display("FAIL jogos_total: got %0d, required 3", jogos_o);
        end
    endtask
`endif

    initial begin
        rst_n       = 1'b0;
        sorteio     = '0;
        novo_jogo   = 1'b0;
        insere      = 1'b0;
        numero      = '0;
        fim         = 1'b0;
        clear_stats = 1'b0;
        m_draw      = '0;
        @(negedge clk);

        test_reset();
        test_prize1();
        test_prize2();
        test_no_prize();
        test_abort();
        test_ignored_inputs();
        test_saturation();
        test_clear_with_score();
        test_back_to_back();
        test_reset_midgame();
`ifdef LOTERIA_JOGOS_COUNT_EN
        test_jogos();
`endif
        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time exceeded, required completion");
        $fatal(1);
    end

endmodule

`default_nettype wire
